// File: rtl/fp_accum_seq.sv
// Multi-operand accumulation sequencer around the combinational FLOAT_ADD stage.
// Optional sticky exponent-all-ones flag is built when FPACC_EXC_FLAG_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; in_ready low, no result presented
// S_ACCUM | accepting operands; acc takes the adder output on each beat
// S_DONE  | final sum on res_data with res_valid high until res_ready
module fp_accum_seq #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_out,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             exc_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

    logic [1:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] len_clamp;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start_acc;
    logic             beat;

    assign len_clamp = (len > MAX_LEN_C) ? MAX_LEN_C : len;
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign start_acc = (state == S_IDLE) && start;
    assign beat      = (state == S_ACCUM) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= 32'h0;
            cnt    <= '0;
            target <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 32'h0;
                        cnt    <= '0;
                        target <= len_clamp;
                        state  <= (len_clamp == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc <= add_out;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == target) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // a start arriving together with res_ready is dropped
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_ACCUM);
    assign res_valid = (state == S_DONE);
    assign res_data  = res_valid ? acc : 32'h0;
    assign busy      = (state != S_IDLE);
    assign add_a     = acc;
    assign add_b     = in_data;

`ifdef FPACC_EXC_FLAG_EN
    logic exc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q <= 1'b0;
        end else if (start_acc) begin
            exc_q <= 1'b0;
        end else if (beat && (add_out[30:23] == 8'hFF)) begin
            exc_q <= 1'b1;
        end
    end

    assign exc_flag = exc_q;
`else
    logic unused_ok;
    assign unused_ok = start_acc ^ beat;
    assign exc_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed self-checking bench for fp_accum_seq; a real-arithmetic model stands in for FLOAT_ADD.
module tb_fp_accum_seq;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_out;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_ready;
    logic             busy;
    logic             exc_flag;

    int n_tests = 0;
    int n_fail  = 0;

    fp_accum_seq #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .exc_flag  (exc_flag)
    );

    always #5 clk = ~clk;

    // single-precision <-> real, normals only; enough for the exact values used here
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7F800000;
        return r2f(f2r(a) + f2r(b));
    endfunction

    assign add_out = fadd(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] op);
        int k;
        in_valid = 1'b1;
        in_data  = op;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("feed_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_res(input string tag, input logic [31:0] exp);
        int k;
        k = 0;
        while (!res_valid && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_data"}, res_data, exp);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int beats;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        res_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_exc", 32'(exc_flag), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // basic sum 1+2+3
        start_batch(3);
        check("basic_in_ready_lat", 32'(in_ready), 32'd1);
        feed(32'h3F800000);
        feed(32'h40000000);
        feed(32'h40400000);
        check("basic_res_lat", 32'(res_valid), 32'd1);
        check("basic_busy_done", 32'(busy), 32'd1);
        finish_res("basic", 32'h40C00000);
        check("basic_res_valid_drop", 32'(res_valid), 32'd0);

        // cancellation
        start_batch(2);
        feed(32'h3F800000);
        feed(32'hBF800000);
        finish_res("cancel", 32'h00000000);

        // len = 0
        start_batch(0);
        check("len0_no_ready0", 32'(in_ready), 32'd0);
        tick();
        check("len0_no_ready1", 32'(in_ready), 32'd0);
        check("len0_valid", 32'(res_valid), 32'd1);
        finish_res("len0", 32'h0);

        // clamp: len=31 accepts exactly MAX_LEN beats
        start_batch(31);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        beats = 0;
        for (int k = 0; k < 40 && !res_valid; k++) begin
            if (in_ready) beats++;
            tick();
        end
        in_valid = 1'b0;
        check("clamp_beats", 32'(beats), 32'd16);
        finish_res("clamp", 32'h41800000);

        // in_valid toggling
        start_batch(4);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h40000000;
            tick();
        end
        in_valid = 1'b0;
        finish_res("toggle", 32'h41000000);

        // res_ready held low
        start_batch(1);
        feed(32'h40000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_data", res_data, 32'h40000000);
            check("hold_valid", 32'(res_valid), 32'd1);
        end
        finish_res("hold", 32'h40000000);

        // start during ACCUM is ignored
        start_batch(3);
        feed(32'h3F800000);
        start_batch(1);
        check("ign_start_busy", 32'(in_ready), 32'd1);
        feed(32'h40000000);
        check("ign_start_cnt", 32'(res_valid), 32'd0);
        feed(32'h40400000);
        finish_res("ign_start", 32'h40C00000);

        // start with res_ready in DONE: just return to IDLE
        start_batch(1);
        feed(32'h3F800000);
        start     = 1'b1;
        len       = CNT_W'(2);
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        check("done_start_drop_busy", 32'(busy), 32'd0);
        tick();
        check("done_start_drop_ready", 32'(in_ready), 32'd0);

        // exponent all-ones
        start_batch(2);
        feed(32'h7F800000);
        feed(32'h3F800000);
        check("exc_data", res_data, 32'h7F800000);
`ifdef FPACC_EXC_FLAG_EN
        check("exc_set", 32'(exc_flag), 32'd1);
`else
        check("exc_tied", 32'(exc_flag), 32'd0);
`endif
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
`ifdef FPACC_EXC_FLAG_EN
        check("exc_sticky_idle", 32'(exc_flag), 32'd1);
`endif
        start_batch(1);
        check("exc_clear", 32'(exc_flag), 32'd0);
        feed(32'h3F800000);
        finish_res("exc_next", 32'h3F800000);

        // reset mid-batch
        start_batch(4);
        feed(32'h3F800000);
        feed(32'h3F800000);
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_res_valid", 32'(res_valid), 32'd0);
        check("mrst_res_data", res_data, 32'h0);
        check("mrst_add_a", add_a, 32'h0);
        check("mrst_exc", 32'(exc_flag), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_batch(1);
        feed(32'h40400000);
        finish_res("post_rst", 32'h40400000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
